// File: rtl/sin_wave_gen.sv
// Full-wave sine NCO: phase accumulator drives quarter-wave table reads,
// quadrant symmetry rebuilds the signed sample two clocks later.
module sin_wave_gen #(
    parameter int PHASE_W = 16,
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     phase_clr,
    input  logic [PHASE_W-1:0]       phase_inc,
    output logic                     tbl_rd,
    output logic [ADDR_W-1:0]        tbl_addr,
    input  logic [DATA_W-1:0]        tbl_dout,
    output logic signed [DATA_W:0]   sample,
    output logic                     sample_valid
);

    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               rd_q, rd_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               va_q, va_d;
    logic               na_q, na_d;
    logic               vb_q, vb_d;
    logic               nb_q, nb_d;
    logic [DATA_W:0]    sample_q, sample_d;
    logic               valid_q, valid_d;

    logic [1:0]         quad;
    logic [ADDR_W-1:0]  idx;
    logic [ADDR_W-1:0]  addr_c;
    logic [DATA_W:0]    mag;

    // Odd quadrants walk the quarter table backwards
    always_comb begin
        quad   = phase_q[PHASE_W-1 -: 2];
        idx    = phase_q[PHASE_W-3 -: ADDR_W];
        addr_c = quad[0] ? ~idx : idx;
    end

    always_comb begin
        phase_d = phase_q;
        if (phase_clr) begin
            phase_d = '0;
        end else if (en) begin
            phase_d = phase_q + phase_inc;
        end
    end

    always_comb begin
        rd_d   = en;
        addr_d = en ? addr_c : addr_q;
        va_d   = en;
        na_d   = en & quad[1];
        vb_d   = va_q;
        nb_d   = na_q;
    end

    // Negation of a zero magnitude wraps back to +0
    always_comb begin
        mag      = {1'b0, tbl_dout};
        sample_d = sample_q;
        if (vb_q) begin
            sample_d = nb_q ? (~mag + 1'b1) : mag;
        end
        valid_d  = vb_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= '0;
            rd_q     <= 1'b0;
            addr_q   <= '0;
            va_q     <= 1'b0;
            na_q     <= 1'b0;
            vb_q     <= 1'b0;
            nb_q     <= 1'b0;
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            phase_q  <= phase_d;
            rd_q     <= rd_d;
            addr_q   <= addr_d;
            va_q     <= va_d;
            na_q     <= na_d;
            vb_q     <= vb_d;
            nb_q     <= nb_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
        end
    end

    assign tbl_rd       = rd_q;
    assign tbl_addr     = addr_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;

endmodule
